// File: rtl/led_mode_scheduler_pkg.sv
// Shared mode encodings, per-mode step limits and the LED pattern decode
// for the 4-LED indicator controller.
package led_mode_scheduler_pkg;

  typedef enum logic [1:0] {
    MODE_SWEEP = 2'd0,
    MODE_BIN   = 2'd1,
    MODE_ALT   = 2'd2,
    MODE_OFF   = 2'd3
  } mode_t;

  localparam logic [3:0] LAST_SWEEP = 4'd5;
  localparam logic [3:0] LAST_BIN   = 4'd15;
  localparam logic [3:0] LAST_ALT   = 4'd1;
  localparam logic [3:0] LAST_OFF   = 4'd0;
  localparam logic [3:0] LED_RESET  = 4'b0001;

  function automatic logic [3:0] last_step(input mode_t m);
    case (m)
      MODE_SWEEP: last_step = LAST_SWEEP;
      MODE_BIN:   last_step = LAST_BIN;
      MODE_ALT:   last_step = LAST_ALT;
      default:    last_step = LAST_OFF;
    endcase
  endfunction

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_SWEEP: next_mode = MODE_BIN;
      MODE_BIN:   next_mode = MODE_ALT;
      MODE_ALT:   next_mode = MODE_OFF;
      default:    next_mode = MODE_SWEEP;
    endcase
  endfunction

  // Any mode/step pair outside a mode's sequence lights nothing.
  function automatic logic [3:0] led_decode(input mode_t m, input logic [3:0] step);
    led_decode = 4'b0000;
    case (m)
      MODE_SWEEP: begin
        case (step)
          4'd0:    led_decode = LED_RESET;
          4'd1:    led_decode = 4'b0010;
          4'd2:    led_decode = 4'b0100;
          4'd3:    led_decode = 4'b1000;
          4'd4:    led_decode = 4'b0100;
          4'd5:    led_decode = 4'b0010;
          default: led_decode = 4'b0000;
        endcase
      end
      MODE_BIN: led_decode = step;
      MODE_ALT: begin
        case (step)
          4'd0:    led_decode = 4'b0101;
          4'd1:    led_decode = 4'b1010;
          default: led_decode = 4'b0000;
        endcase
      end
      default: led_decode = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-FF sync -> stability counter -> debounced level plus a
// registered one-cycle press pulse on the debounced rising edge.
module btn_debounce #(
  parameter int DEB_W = 20
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN,
  output logic LEVEL,
  output logic PRESS
);

  logic             sync1;
  logic             sync2;
  logic             level_d;
  logic [DEB_W-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      cnt     <= '0;
      LEVEL   <= 1'b0;
      level_d <= 1'b0;
      PRESS   <= 1'b0;
    end else begin
      sync1 <= BTN;
      sync2 <= sync1;
      // Any bounce back to the current level restarts the stability window.
      if (sync2 == LEVEL) begin
        cnt <= '0;
      end else if (&cnt) begin
        LEVEL <= ~LEVEL;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      level_d <= LEVEL;
      PRESS   <= LEVEL & ~level_d;
    end
  end

endmodule

// File: rtl/led_mode_scheduler.sv
// 4-LED indicator controller: debounced mode/speed buttons, free-running
// prescaler, mode/step FSM and a combinational pattern decode.
module led_mode_scheduler
  import led_mode_scheduler_pkg::*;
#(
  parameter int DIV_W = 23,
  parameter int DEB_W = 20
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_MODE,
  input  logic       BTN_SPEED,
  output logic [3:0] LED,
  output logic [1:0] MODE,
  output logic [1:0] SPEED
);

  logic             mode_press;
  logic             speed_press;
  logic             mode_level;
  logic             speed_level;
  logic             unused_levels;
  logic [DIV_W-1:0] pre;
  logic [DIV_W-1:0] tick_mask;
  logic             tick;
  logic [1:0]       speed;
  logic [3:0]       step;
  mode_t            mode;

  btn_debounce #(.DEB_W(DEB_W)) u_deb_mode (
    .CLK   (CLK),
    .RST   (RST),
    .BTN   (BTN_MODE),
    .LEVEL (mode_level),
    .PRESS (mode_press)
  );

  btn_debounce #(.DEB_W(DEB_W)) u_deb_speed (
    .CLK   (CLK),
    .RST   (RST),
    .BTN   (BTN_SPEED),
    .LEVEL (speed_level),
    .PRESS (speed_press)
  );

  // Only the press pulses drive behaviour; the held levels are not needed here.
  assign unused_levels = &{1'b0, mode_level, speed_level};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Each speed step halves the period by dropping one more top bit from the tick test.
  assign tick_mask = {DIV_W{1'b1}} >> speed;
  assign tick      = &(pre | ~tick_mask);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      speed <= 2'd0;
    end else if (speed_press) begin
      speed <= speed + 2'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode <= MODE_SWEEP;
      step <= 4'd0;
    end else if (mode_press) begin
      mode <= next_mode(mode);
      step <= 4'd0;
    end else if (tick && mode != MODE_OFF) begin
      step <= (step == last_step(mode)) ? 4'd0 : step + 4'd1;
    end
  end

  assign LED   = led_decode(mode, step);
  assign MODE  = mode;
  assign SPEED = speed;

endmodule
